// File: rtl/sixteen_by_eight_divider.sv
// -----------------------------------------------------------------------------
// sixteen_by_eight_divider
//
// Unsigned 16-bit / 8-bit restoring shift-subtract divider. It produces one
// quotient bit per clock, MSB first, so a division takes 16 RUN cycles
// followed by a single DONE cycle.
//
// Configuration macro: DIV_ZERO_FAST_EN
//   defined   : a start with divisor == 0 goes straight from IDLE to DONE.
//               div_err is raised and busy is never asserted.
//   undefined : divisor == 0 runs the normal 16 iterations and div_err is
//               tied low.
//   In both builds a zero divisor yields quotient = 16'hFFFF and
//   remainder = dividend[7:0].
//
// Ports
//   clk        : single clock; all state updates on the rising edge.
//   rst_n      : synchronous, active-low reset.
//   start      : request a division; sampled only in IDLE.
//   dividend   : 16-bit unsigned numerator, captured when start is accepted.
//   divisor    : 8-bit unsigned denominator, captured when start is accepted.
//   busy       : high during the 16 iteration cycles.
//   done       : one-cycle pulse; quotient/remainder/div_err are valid.
//   quotient   : registered floor(dividend / divisor).
//   remainder  : registered dividend mod divisor.
//   div_err    : registered divide-by-zero flag, valid with done.
// -----------------------------------------------------------------------------
module sixteen_by_eight_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  // Dividend bits shift out of the top while quotient bits shift in at the
  // bottom. After 16 iterations the register holds the full quotient.
  logic [15:0] shift_reg, shift_next;
  logic [7:0]  part_reg, part_next;
  logic [7:0]  divisor_reg, divisor_next;
  logic [15:0] quotient_reg, quotient_next;
  logic [7:0]  remainder_reg, remainder_next;
`ifdef DIV_ZERO_FAST_EN
  logic        err_reg, err_next;
`endif

  // One restoring step. The trial value is the 9-bit partial remainder.
  // The stored remainder is always < divisor, so it fits in 8 bits. Shifting
  // in one more dividend bit needs 9 bits, and that is why no intermediate
  // overflow can occur.
  logic [8:0]  trial;
  logic        q_bit;
  logic [7:0]  sub;
  logic [7:0]  part_step;

  assign trial     = {part_reg, shift_reg[15]};
  assign q_bit     = (trial >= {1'b0, divisor_reg});
  // When q_bit is set, the true difference is < divisor <= 255. Modulo-256
  // subtraction on the low byte is therefore exact. A zero divisor always
  // subtracts nothing, so all quotient bits become 1 and the remainder ends
  // up as the low dividend byte.
  assign sub       = trial[7:0] - divisor_reg;
  assign part_step = q_bit ? sub : trial[7:0];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= 4'd0;
      shift_reg     <= 16'd0;
      part_reg      <= 8'd0;
      divisor_reg   <= 8'd0;
      quotient_reg  <= 16'd0;
      remainder_reg <= 8'd0;
`ifdef DIV_ZERO_FAST_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      shift_reg     <= shift_next;
      part_reg      <= part_next;
      divisor_reg   <= divisor_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
`ifdef DIV_ZERO_FAST_EN
      err_reg       <= err_next;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    shift_next     = shift_reg;
    part_next      = part_reg;
    divisor_next   = divisor_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
`ifdef DIV_ZERO_FAST_EN
    err_next       = err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next   = dividend;
          part_next    = 8'd0;
          divisor_next = divisor;
          count_next   = 4'd0;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == 8'd0) begin
            state_next     = DONE;
            quotient_next  = 16'hFFFF;
            remainder_next = dividend[7:0];
            err_next       = 1'b1;
          end else begin
            state_next     = RUN;
          end
`else
          state_next = RUN;
`endif
        end
      end

      RUN: begin
        shift_next = {shift_reg[14:0], q_bit};
        part_next  = part_step;
        count_next = count_reg + 4'd1;
        // Results are loaded only on the transition into DONE. They then
        // hold until the next DONE or reset.
        if (count_reg == 4'd15) begin
          state_next     = DONE;
          quotient_next  = {shift_reg[14:0], q_bit};
          remainder_next = part_step;
`ifdef DIV_ZERO_FAST_EN
          err_next       = 1'b0;
`endif
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
`ifdef DIV_ZERO_FAST_EN
  assign div_err   = err_reg;
`else
  assign div_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sixteen_by_eight_divider.sv
// -----------------------------------------------------------------------------
// tb_sixteen_by_eight_divider
//
// Directed-vector self-checking bench for sixteen_by_eight_divider. Every
// expected value below is hand-computed. Cycle numbering treats the cycle
// in which start is accepted as cycle 0.
// -----------------------------------------------------------------------------
module tb_sixteen_by_eight_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_err;

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int busy_seen = 0;
  int done_cnt  = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int   ZLAT  = 1;
  localparam int   ZBUSY = 0;
  localparam logic ZERR  = 1'b1;
`else
  localparam int   ZLAT  = 17;
  localparam int   ZBUSY = 16;
  localparam logic ZERR  = 1'b0;
`endif

  always #5 clk = ~clk;

  sixteen_by_eight_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic step();
    if (busy) busy_seen++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a one-cycle start. The operands are scrambled right after the
  // accept edge, so any failure to latch them shows up in the result.
  task automatic launch(input logic [15:0] dvd, input logic [7:0] dsr);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dsr;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = ~dvd;
    divisor   = ~dsr;
    cyc       = 1;
    busy_seen = 0;
  endtask

  task automatic wait_done();
    while (!done && cyc < 40) step();
  endtask

  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dsr,
                        input logic [15:0] eq, input logic [7:0] er,
                        input int elat, input int ebusy, input logic eerr);
    logic [15:0] q_at_done;
    launch(dvd, dsr);
    wait_done();
    q_at_done = quotient;
    check({tag, "_done"}, done, 1);
    check({tag, "_lat"}, cyc, elat);
    check({tag, "_busycnt"}, busy_seen, ebusy);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_err"}, div_err, eerr);
    $display("op %s: %04h / %02h -> q=%04h r=%02h err=%0d lat=%0d", tag, dvd, dsr,
             q_at_done, remainder, div_err, cyc);
    step();
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold_q"}, quotient, eq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_err", div_err, 0);
    rst_n = 1'b1;
    step();

    // Basic vectors and boundary values.
    run_op("r026",   16'h03E8, 8'h07, 16'h008E, 8'h06, 17, 16, 1'b0);
    run_op("r027a",  16'hFFFF, 8'hFF, 16'h0101, 8'h00, 17, 16, 1'b0);
    run_op("r027b",  16'h0005, 8'h0A, 16'h0000, 8'h05, 17, 16, 1'b0);
    run_op("r028",   16'h1234, 8'h00, 16'hFFFF, 8'h34, ZLAT, ZBUSY, ZERR);
    run_op("eq",     16'h00FF, 8'hFF, 16'h0001, 8'h00, 17, 16, 1'b0);
    run_op("maxrem", 16'h00FE, 8'hFF, 16'h0000, 8'hFE, 17, 16, 1'b0);
    run_op("div1",   16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 17, 16, 1'b0);
    run_op("mix",    16'hABCD, 8'h10, 16'h0ABC, 8'h0D, 17, 16, 1'b0);
    run_op("zero0",  16'h0000, 8'h00, 16'hFFFF, 8'h00, ZLAT, ZBUSY, ZERR);

    // A start during RUN, with changed inputs, must be ignored.
    launch(16'h0064, 8'h0A);
    while (cyc < 5) step();
    start    = 1'b1;
    dividend = 16'hFFFF;
    divisor  = 8'h01;
    step();
    start = 1'b0;
    wait_done();
    check("r029_lat", cyc, 17);
    check("r029_q", quotient, 16'h000A);
    check("r029_r", remainder, 8'h00);
    $display("op r029: 0064 / 0a with mid-run start -> q=%04h r=%02h lat=%0d", quotient, remainder, cyc);
    done_cnt = 0;
    repeat (20) begin
      step();
      if (done) done_cnt++;
    end
    check("r029_noqueue", done_cnt, 0);
    check("r029_hold_q", quotient, 16'h000A);
    check("r029_idle_busy", busy, 0);

    // A reset in the middle of RUN aborts the operation and clears the results.
    launch(16'h03E8, 8'h07);
    while (cyc < 8) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("r030_busy", busy, 0);
    check("r030_done", done, 0);
    check("r030_q", quotient, 0);
    check("r030_r", remainder, 0);
    check("r030_err", div_err, 0);
    done_cnt = 0;
    repeat (20) begin
      step();
      if (done) done_cnt++;
    end
    check("r030_nodone", done_cnt, 0);
    $display("op r030: reset at cycle 8 aborted operation");
    run_op("r030b", 16'h0010, 8'h03, 16'h0005, 8'h01, 17, 16, 1'b0);

    // Back-to-back: run_op returns in cycle 18 of the first operation, so
    // the second launch starts in cycle 18 and must finish 17 cycles later
    // (cycle 35).
    run_op("b2b_a", 16'h1000, 8'h40, 16'h0040, 8'h00, 17, 16, 1'b0);
    run_op("b2b_b", 16'h7FFF, 8'h80, 16'h00FF, 8'h7F, 17, 16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sixteen_by_eight_divider.md
SIXTEEN_BY_EIGHT_DIVIDER -- requirements
Module: sixteen_by_eight_divider

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  16  unsigned numerator; captured when start is accepted.
REQ-006 divisor  input  8  unsigned denominator; captured when start is accepted.
REQ-007 busy  output  1  high while an iteration is in progress.
REQ-008 done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-009 quotient  output  16  registered result, floor(dividend/divisor).
REQ-010 remainder  output  8  registered result, dividend mod divisor.
REQ-011 div_err  output  1  divide-by-zero flag; registered, valid with done.

Function
REQ-012 SHALL implement an unsigned restoring shift-subtract divider with one quotient bit per cycle, MSB first, and a 9-bit partial remainder so that no intermediate overflow occurs.
REQ-013 SHALL use FSM states IDLE, RUN, DONE: IDLE->RUN on start=1; RUN->DONE after the 16th iteration; DONE->IDLE unconditionally after one cycle.
REQ-014 Cycle of accepted start = cycle 0; RUN occupies cycles 1-16 with busy=1; DONE is cycle 17 with done=1 and busy=0; total latency 17 cycles from start to done.
REQ-015 Operands SHALL be latched on accept; input changes during RUN SHALL NOT affect the result.
REQ-016 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-017 quotient, remainder, and div_err SHALL update only when entering DONE and SHALL hold until the next DONE or reset.
REQ-018 A start asserted in the same cycle the FSM returns to IDLE (cycle 18) SHALL be accepted, allowing back-to-back operations every 18 cycles.
REQ-019 For all nonzero divisors, quotient*divisor+remainder SHALL equal dividend, with remainder < divisor.
REQ-020 dividend < divisor SHALL yield quotient=0 and remainder=dividend[7:0].
REQ-021 divisor=0 SHALL yield quotient=16'hFFFF and remainder=dividend[7:0] in all configurations.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_err=0, and clear the iteration counter.
REQ-023 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start accepted after release SHALL begin a fresh 17-cycle operation.

Configuration
REQ-024 Macro DIV_ZERO_FAST_EN: when defined, a start with divisor=0 SHALL go IDLE->DONE directly (done at cycle 1, busy never asserted) with div_err=1 and the results of REQ-021.
REQ-025 When DIV_ZERO_FAST_EN is undefined, divisor=0 SHALL run the full 16 iterations, done SHALL occur at cycle 17, div_err SHALL be tied to 0, and results SHALL follow REQ-021.

Verification
REQ-026 dividend=16'h03E8, divisor=8'h07, start pulse -> busy for 16 cycles, done at cycle 17, quotient=16'h008E, remainder=8'h06.
REQ-027 dividend=16'hFFFF, divisor=8'hFF -> quotient=16'h0101, remainder=8'h00; then dividend=16'h0005, divisor=8'h0A -> quotient=0, remainder=8'h05.
REQ-028 dividend=16'h1234, divisor=0 -> quotient=16'hFFFF, remainder=8'h34; with macro, done at cycle 1 and div_err=1; without macro, done at cycle 17 and div_err=0.
REQ-029 Start 16'h0064/8'h0A, then at cycle 5 pulse start and change inputs to 16'hFFFF/8'h01 -> ignored; result quotient=16'h000A, remainder=0; outputs held until the next done.
REQ-030 Start 16'h03E8/8'h07, rst_n=0 at cycle 8 for 1 cycle -> all outputs 0 and no done; new start 16'h0010/8'h03 -> done 17 cycles later, quotient=16'h0005, remainder=8'h01.
REQ-031 Back-to-back: second start asserted at cycle 18 SHALL be accepted and produce done at cycle 35.
